mmio_slot_initiator: RTL

Bus-side initiator for the MMIO slot interface. It accepts single read/write requests from the CPU/interconnect over a valid/ready request channel and decodes the slot index from the request address. It then drives the one-hot-selected slot through the full slot handshake and returns read data plus an error code over a valid/ready response channel. It sits between the core's load/store path and the MMIO peripherals (timer, GPIO, UART, …) that implement the slot interface.

---
 rtl/mmio_slot_initiator.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mmio_slot_initiator.sv
// mmio_slot_initiator: bus-side initiator that runs single requests through the MMIO slot handshake
//
// Ports:
//   clk, arst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready                request handshake (req_ready is high only in IDLE)
//   req_write, req_addr, req_wdata     request: [7:0] register offset, [8+SLOT_BITS-1:8] slot index
//   resp_valid/resp_ready              response handshake
//   resp_rdata, resp_err               read data and status: 00 ok, 01 slave, 10 decode, 11 timeout
//   chip_select, read, write,          one-hot slot select plus shared command bus
//   addr, wr_data
//   transaction_completed              one-cycle release pulse broadcast to all slots
//   rd_data, rd_done, wr_done,         per-slot return data and status
//   slave_error, decode_error
//
// Optional feature: define MMIO_SLOT_INIT_TIMEOUT_EN to bound ISSUE at TIMEOUT_CYCLES cycles
// (error 11). Without it ISSUE waits for done indefinitely.
module mmio_slot_initiator #(
    parameter int NUM_SLOTS      = 8,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_rdata,
    output logic [1:0]                resp_err,
    output logic [NUM_SLOTS-1:0]      chip_select,
    output logic                      read,
    output logic                      write,
    output logic [7:0]                addr,
    output logic [31:0]               wr_data,
    output logic                      transaction_completed,
    input  logic [32*NUM_SLOTS-1:0]   rd_data,
    input  logic [NUM_SLOTS-1:0]      rd_done,
    input  logic [NUM_SLOTS-1:0]      wr_done,
    input  logic [NUM_SLOTS-1:0]      slave_error,
    input  logic [NUM_SLOTS-1:0]      decode_error
);
    localparam int SLOT_BITS = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nx;
    logic [NUM_SLOTS-1:0] cs_nx;
    logic read_nx, write_nx, rv_nx, tc_nx;
    logic [7:0] addr_nx;
    logic [31:0] wd_nx, rdata_nx, sel_rdata;
    logic [1:0] err_nx;
    logic [SLOT_BITS-1:0] slot_idx;
    logic in_range, done, sel_derr, sel_serr, expired, unused_addr;
`ifdef MMIO_SLOT_INIT_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt, cnt_nx;
    assign expired = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
    assign expired = 1'b0;
`endif
    assign slot_idx    = req_addr[8+SLOT_BITS-1:8];
    // Extra bit so non-power-of-two slot counts can reject the unused indices
    assign in_range    = {1'b0, slot_idx} < (SLOT_BITS+1)'(NUM_SLOTS);
    // chip_select is one-hot and stable in ISSUE, so masking with it picks the selected slot only
    assign done        = |(chip_select & (rd_done | wr_done));
    assign sel_derr    = |(chip_select & decode_error);
    assign sel_serr    = |(chip_select & slave_error);
    assign req_ready   = (state == IDLE);
    // Address bits above the slot index are deliberately ignored
    assign unused_addr = ^req_addr;

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (chip_select[i]) sel_rdata = rd_data[32*i +: 32];
    end

    always_comb begin
        state_nx = state;
        cs_nx    = chip_select;
        read_nx  = read;
        write_nx = write;
        addr_nx  = addr;
        wd_nx    = wr_data;
        rv_nx    = resp_valid;
        rdata_nx = resp_rdata;
        err_nx   = resp_err;
        tc_nx    = 1'b0;
`ifdef MMIO_SLOT_INIT_TIMEOUT_EN
        cnt_nx   = cnt;
`endif
        case (state)
            IDLE: if (req_valid) begin
                if (in_range) begin
                    state_nx = ISSUE;
                    cs_nx    = NUM_SLOTS'(1) << slot_idx;
                    read_nx  = !req_write;
                    write_nx = req_write;
                    addr_nx  = req_addr[7:0];
                    wd_nx    = req_wdata;
`ifdef MMIO_SLOT_INIT_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end else begin
                    state_nx = RESP;
                    rv_nx    = 1'b1;
                    rdata_nx = '0;
                    err_nx   = 2'b10;
                end
            end
            // Done is tested ahead of expiry so a same-cycle done wins
            ISSUE: if (done || expired) begin
                state_nx = RESP;
                rv_nx    = 1'b1;
                tc_nx    = 1'b1;
                cs_nx    = '0;
                read_nx  = 1'b0;
                write_nx = 1'b0;
                addr_nx  = '0;
                wd_nx    = '0;
                rdata_nx = (done && read && !sel_derr && !sel_serr) ? sel_rdata : '0;
                err_nx   = !done ? 2'b11 : sel_derr ? 2'b10 : sel_serr ? 2'b01 : 2'b00;
            end
`ifdef MMIO_SLOT_INIT_TIMEOUT_EN
            else cnt_nx = cnt + 1'b1;
`endif
            RESP: if (resp_ready) begin
                state_nx = IDLE;
                rv_nx    = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state                 <= IDLE;
            chip_select           <= '0;
            read                  <= 1'b0;
            write                 <= 1'b0;
            addr                  <= '0;
            wr_data               <= '0;
            resp_valid            <= 1'b0;
            resp_rdata            <= '0;
            resp_err              <= 2'b00;
            transaction_completed <= 1'b0;
`ifdef MMIO_SLOT_INIT_TIMEOUT_EN
            cnt                   <= '0;
`endif
        end else begin
            state                 <= state_nx;
            chip_select           <= cs_nx;
            read                  <= read_nx;
            write                 <= write_nx;
            addr                  <= addr_nx;
            wr_data               <= wd_nx;
            resp_valid            <= rv_nx;
            resp_rdata            <= rdata_nx;
            resp_err              <= err_nx;
            transaction_completed <= tc_nx;
`ifdef MMIO_SLOT_INIT_TIMEOUT_EN
            cnt                   <= cnt_nx;
`endif
        end
    end
endmodule
